// File: rtl/bcd_calc_pkg.sv
// bcd_calc_pkg: shared state encoding, key codes and digit test for the BCD calculator
package bcd_calc_pkg;
    typedef enum logic [1:0] {
        ENTRADA_A = 2'd0,
        ENTRADA_B = 2'd1,
        CALCULO   = 2'd2,
        MOSTRAR   = 2'd3
    } estado_t;
    localparam logic [3:0] TECLA_SUMA   = 4'hA;
    localparam logic [3:0] TECLA_IGUAL  = 4'hB;
    localparam logic [3:0] TECLA_BORRAR = 4'hC;
    function automatic logic es_digito(input logic [3:0] code);
        return code <= 4'd9;
    endfunction
endpackage

// File: rtl/bcd_calc_ctrl_sumador.sv
// bcd_sumador: combinational 3-digit BCD adder producing a 4-digit BCD sum
module bcd_sumador (
    input  logic [11:0] bcd_1,
    input  logic [11:0] bcd_2,
    output logic [15:0] suma
);
    logic [3:0] c;
    assign c[0] = 1'b0;
    for (genvar g = 0; g < 3; g++) begin : gen_dig
        logic [4:0] s;
        logic [4:0] s_adj;
        assign s        = {1'b0, bcd_1[4*g +: 4]} + {1'b0, bcd_2[4*g +: 4]} + {4'b0, c[g]};
        assign s_adj    = s + 5'd6;
        assign c[g+1]   = s > 5'd9;
        assign suma[4*g +: 4] = c[g+1] ? s_adj[3:0] : s[3:0];
    end
    assign suma[15:12] = {3'b0, c[3]};
endmodule

// File: rtl/bcd_calc_ctrl.sv
// bcd_calc_ctrl: builds two BCD operands from keypad codes, adds them on "=" and holds the sum
module bcd_calc_ctrl
    import bcd_calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tecla_valida,
    input  logic [3:0]  tecla_codigo,
    output logic [11:0] operando_a,
    output logic [11:0] operando_b,
    output logic [15:0] resultado,
    output logic [15:0] display_bcd,
    output estado_t     estado,
    output logic        listo
);
    estado_t     estado_sig;
    logic [1:0]  cnt_a;
    logic [1:0]  cnt_b;
    logic [15:0] suma;
    logic        dig;
    logic        es_suma;
    logic        es_igual;
    logic        es_borrar;
    bcd_sumador u_sumador (
        .bcd_1 (operando_a),
        .bcd_2 (operando_b),
        .suma  (suma)
    );
    assign dig       = tecla_valida && es_digito(tecla_codigo);
    assign es_suma   = tecla_valida && tecla_codigo == TECLA_SUMA;
    assign es_igual  = tecla_valida && tecla_codigo == TECLA_IGUAL;
    assign es_borrar = tecla_valida && tecla_codigo == TECLA_BORRAR;
    assign display_bcd = estado == MOSTRAR ? resultado
                       : {4'h0, estado == ENTRADA_A ? operando_a : operando_b};
    always_ff @(posedge clk) begin
        if (rst) estado <= ENTRADA_A;
        else     estado <= estado_sig;
    end
    always_comb begin
        estado_sig = estado;
        case (estado)
            ENTRADA_A: estado_sig = es_borrar ? ENTRADA_A : es_suma ? ENTRADA_B : ENTRADA_A;
            ENTRADA_B: estado_sig = es_borrar ? ENTRADA_A : es_igual ? CALCULO : ENTRADA_B;
            CALCULO:   estado_sig = MOSTRAR;
            MOSTRAR:   estado_sig = (es_borrar || dig) ? ENTRADA_A : MOSTRAR;
            default:   estado_sig = ENTRADA_A;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            operando_a <= '0;
            operando_b <= '0;
            resultado  <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            listo      <= 1'b0;
        end else begin
            listo <= estado == CALCULO;
            if (estado == CALCULO) resultado <= suma;
            if (es_borrar && estado != CALCULO) begin
                operando_a <= '0;
                operando_b <= '0;
                cnt_a      <= '0;
                cnt_b      <= '0;
            end else begin
                case (estado)
                    ENTRADA_A: begin
                        if (dig && cnt_a != 2'd3) begin
                            operando_a <= {operando_a[7:0], tecla_codigo};
                            cnt_a      <= cnt_a + 2'd1;
                        end
                        if (es_suma) begin
                            operando_b <= '0;
                            cnt_b      <= '0;
                        end
                    end
                    ENTRADA_B: begin
                        if (dig && cnt_b != 2'd3) begin
                            operando_b <= {operando_b[7:0], tecla_codigo};
                            cnt_b      <= cnt_b + 2'd1;
                        end
                    end
                    MOSTRAR: begin
                        // a digit after a result starts a fresh calculation with it
                        if (dig) begin
                            operando_a <= {8'h0, tecla_codigo};
                            cnt_a      <= 2'd1;
                            operando_b <= '0;
                            cnt_b      <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bcd_calc_ctrl.sv
// tb_bcd_calc_ctrl: directed and random key sequences checked against a decimal reference model
module tb_bcd_calc_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tecla_valida = 1'b0;
    logic [3:0]  tecla_codigo = 4'h0;
    logic [11:0] operando_a;
    logic [11:0] operando_b;
    logic [15:0] resultado;
    logic [15:0] display_bcd;
    bcd_calc_pkg::estado_t estado;
    logic        listo;
    int total = 0;
    int bad = 0;
    int m_state = 0, m_a = 0, m_b = 0, m_na = 0, m_nb = 0, m_res = 0;
    logic m_listo = 1'b0;
    bcd_calc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .tecla_valida (tecla_valida),
        .tecla_codigo (tecla_codigo),
        .operando_a   (operando_a),
        .operando_b   (operando_b),
        .resultado    (resultado),
        .display_bcd  (display_bcd),
        .estado       (estado),
        .listo        (listo)
    );
    always #5 clk = ~clk;
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic model(input logic r, input logic v, input int k);
        logic nl;
        if (r) begin
            m_state = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_res = 0; m_listo = 1'b0;
            return;
        end
        nl = (m_state == 2);
        if (m_state == 2) begin
            m_res = m_a + m_b;
            m_state = 3;
        end else if (v) begin
            if (k == 12) begin
                m_state = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0;
            end else if (k <= 9) begin
                if (m_state == 0 && m_na < 3) begin m_a = m_a * 10 + k; m_na++; end
                else if (m_state == 1 && m_nb < 3) begin m_b = m_b * 10 + k; m_nb++; end
                else if (m_state == 3) begin m_a = k; m_na = 1; m_b = 0; m_nb = 0; m_state = 0; end
            end else if (k == 10 && m_state == 0) begin
                m_state = 1; m_b = 0; m_nb = 0;
            end else if (k == 11 && m_state == 1) begin
                m_state = 2;
            end
        end
        m_listo = nl;
    endtask
    task automatic step(input logic r, input logic v, input logic [3:0] k);
        @(negedge clk);
        rst = r; tecla_valida = v; tecla_codigo = k;
        @(posedge clk);
        model(r, v, int'(k));
        #1;
        chk("estado", 16'(estado), 16'(m_state));
        chk("operando_a", 16'(operando_a), to_bcd(m_a));
        chk("operando_b", 16'(operando_b), to_bcd(m_b));
        chk("resultado", resultado, to_bcd(m_res));
        chk("display_bcd", display_bcd,
            m_state == 3 ? to_bcd(m_res) : to_bcd(m_state == 0 ? m_a : m_b));
        chk("listo", 16'(listo), 16'(m_listo));
    endtask
    task automatic press(input logic [3:0] k);
        step(1'b0, 1'b1, k);
    endtask
    task automatic idle();
        step(1'b0, 1'b0, 4'h0);
    endtask
    initial begin
        step(1'b1, 1'b0, 4'h0);
        chk("reset_disp", display_bcd, 16'h0000);
        press(1); press(2); press(3); press(4'hA); press(4); press(5); press(6);
        chk("a_123", 16'(operando_a), 16'h0123);
        chk("b_456", 16'(operando_b), 16'h0456);
        press(4'hB);
        chk("calc_no_listo", 16'(listo), 16'h0);
        idle();
        chk("res_579", resultado, 16'h0579);
        chk("listo_579", 16'(listo), 16'h1);
        chk("mostrar", 16'(estado), 16'h3);
        idle();
        chk("listo_drop", 16'(listo), 16'h0);
        press(8);
        chk("restart_disp", display_bcd, 16'h0008);
        chk("restart_b", 16'(operando_b), 16'h0);
        press(4'hA); press(4'hB); idle();
        chk("res_8", resultado, 16'h0008);
        press(4'hC);
        press(9); press(9); press(9); press(4'hA); press(9); press(9); press(9); press(4'hB); idle();
        chk("res_1998", resultado, 16'h1998);
        press(4'hC);
        press(0); press(0); press(5); press(4'hA); press(0); press(9); press(5); press(4'hB); idle();
        chk("res_100", resultado, 16'h0100);
        press(4'hC);
        press(1); press(2); press(3); press(4);
        chk("a_sat", 16'(operando_a), 16'h0123);
        press(4'hB); idle(); idle();
        chk("igual_in_a", 16'(estado), 16'h0);
        press(7); press(4'hA); press(4'hC);
        chk("borrar_a", 16'(operando_a), 16'h0);
        chk("borrar_keep_res", resultado, 16'h0100);
        press(1); press(4'hA); press(2); press(3);
        step(1'b1, 1'b1, 4'h5);
        chk("rst_mid_res", resultado, 16'h0);
        chk("rst_mid_b", 16'(operando_b), 16'h0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)));
        end
        tecla_valida = 1'b0;
        rst = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_calc_ctrl.md
Name: bcd_calc_ctrl

Overview:
Sequencing controller for the 3-digit BCD adder (bcd_sumador). It accepts one keypad code per cycle and builds operand A, then operand B, digit by digit. On "=" it drives both operands into the adder, latches the 4-digit BCD sum and holds it for display. It sits between the keypad decoder and the 7-segment display driver.

Parameters:
TECLA_SUMA, 4'hA, key code meaning "+": close operand A and start operand B.
TECLA_IGUAL, 4'hB, key code meaning "=": close operand B and compute.
TECLA_BORRAR, 4'hC, key code meaning clear-all.

Ports:
clk  input  1  system clock, all state on the rising edge.
rst  input  1  synchronous, active-high reset.
tecla_valida  input  1  one-cycle strobe; tecla_codigo is valid while high.
tecla_codigo  input  4  0-9 = digit; TECLA_SUMA / TECLA_IGUAL / TECLA_BORRAR = commands; other codes are ignored.
operando_a  output  12  registered BCD operand A {centenas, decenas, unidades}.
operando_b  output  12  registered BCD operand B.
resultado  output  16  registered BCD sum {miles, centenas, decenas, unidades}.
display_bcd  output  16  value to show: {4'h0, operand being entered} in entry states, resultado in MOSTRAR.
estado  output  2  current state encoding, from the package.
listo  output  1  one-cycle pulse when resultado is updated.

Behaviour:
- Reset (rst=1 at an edge, any state, mid-operation included): state=ENTRADA_A. operando_a, operando_b, resultado = 0; digit counters = 0; listo = 0; display_bcd = 0. Reset dominates tecla_valida.
- Nothing changes unless tecla_valida=1, except the CALCULO state, which self-advances.
- ENTRADA_A:
  - digit d with counter < 3: operando_a <= {operando_a[7:0], d}; counter++.
  - digit d with counter = 3: ignored (no shift, no wrap).
  - SUMA: -> ENTRADA_B; operando_b <= 0; counter_b <= 0. Zero digits entered is allowed; A = 000.
  - IGUAL: ignored.
- ENTRADA_B:
  - Same digit rules, applied to operando_b.
  - IGUAL: -> CALCULO (zero digits allowed).
  - SUMA: ignored.
- CALCULO (exactly 1 cycle, ignores keys): resultado <= adder output of (operando_a, operando_b); -> MOSTRAR; listo=1 in the cycle after the capture edge.
- Latency: IGUAL sampled at edge N; resultado and listo are valid after edge N+1 (2 cycles from key to result).
- MOSTRAR:
  - resultado is held.
  - digit d: -> ENTRADA_A with operando_a <= {8'h0, d}, counter_a=1, operando_b <= 0.
  - SUMA / IGUAL: ignored.
- BORRAR in any state except CALCULO: identical to reset, except resultado is kept. BORRAR in CALCULO is ignored.
- Adder arithmetic: the adder is fully combinational, operands are registered, and there is no path from keys to the adder in the same cycle. Max sum 999+999 = 1998 (16'h1998). Miles digit is 0 or 1.
- Non-BCD codes 4'hD-4'hF: ignored in all states.
- listo is low in every cycle other than the one defined above.

Decomposition:
- Package bcd_calc_pkg:
  - typedef enum logic [1:0] estado_t {ENTRADA_A=0, ENTRADA_B=1, CALCULO=2, MOSTRAR=3}.
  - Default key-code constants TECLA_SUMA, TECLA_IGUAL, TECLA_BORRAR.
  - Function es_digito(code) returning code <= 9.
- Sub-module: instantiate the existing bcd_sumador (bcd_1=operando_a, bcd_2=operando_b) internally; no other sub-module.
- FSM plus two 2-bit digit counters plus result register in the controller (~150-200 lines).

Test Plan:
- Keys 1,2,3,SUMA,4,5,6,IGUAL -> operando_a=12'h123, operando_b=12'h456; 2 cycles after IGUAL resultado=16'h0579, listo high for exactly 1 cycle, estado=MOSTRAR.
- Keys 9,9,9,SUMA,9,9,9,IGUAL -> resultado=16'h1998. Keys 0,0,5,SUMA,0,9,5,IGUAL -> resultado=16'h0100 (carry chain).
- Keys 1,2,3,4 in ENTRADA_A -> operando_a stays 12'h123; then IGUAL -> no state change, listo never asserts.
- Keys 7,SUMA,BORRAR -> estado=ENTRADA_A, operandos=0, display_bcd=0, previous resultado retained.
- After result 16'h0579, key 8 -> estado=ENTRADA_A, display_bcd=16'h0008, operando_b=0. Then SUMA,IGUAL -> resultado=16'h0008.
- Assert rst for 1 cycle during ENTRADA_B after 2 digits, concurrent with tecla_valida=1 -> all outputs 0, estado=ENTRADA_A, key discarded.
